// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master round-robin arbiter in front of the single-ported
// data memory/IO block. Each transfer is IDLE -> ACCESS -> RESP, so a master
// gets one transfer per three cycles at best. Under contention the master
// that was not served last wins.
module dmem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clock,
  input  logic          reset,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,

  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic [1:0]    owner,
  output logic [CW-1:0] m0_xfers,
  output logic [CW-1:0] m1_xfers
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t        state_q,     state_d;
  logic          grant_q,     grant_d;      // 0 = m0, 1 = m1
  logic          last_q,      last_d;       // master served most recently
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata0_q,    rdata0_d;
  logic [DW-1:0] rdata1_q,    rdata1_d;
  logic [CW-1:0] xfers0_q,    xfers0_d;
  logic [CW-1:0] xfers1_q,    xfers1_d;

  logic          pick;
  logic          in_resp;

  // Winner selection: a lone requester wins outright; on a tie the master
  // that was not served last wins.
  always_comb begin
    pick = 1'b0;
    if (m0_req && m1_req) begin
      pick = ~last_q;
    end else begin
      pick = ~m0_req;
    end
  end

  // Next-state logic. The request fields are captured straight into the
  // memory-side registers on the grant edge, which both latches them against
  // later input changes and presents them to memory during ACCESS.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    xfers0_d    = xfers0_q;
    xfers1_d    = xfers1_q;

    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          state_d = ST_ACCESS;
          grant_d = pick;
          if (pick) begin
            mem_we_d    = m1_we;
            mem_addr_d  = m1_addr;
            mem_wdata_d = m1_wdata;
          end else begin
            mem_we_d    = m0_we;
            mem_addr_d  = m0_addr;
            mem_wdata_d = m0_wdata;
          end
        end
      end

      ST_ACCESS: begin
        state_d = ST_RESP;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        last_d  = grant_q;
        if (grant_q) begin
          rdata1_d = mem_rdata;
          if (xfers1_q != '1) begin
            xfers1_d = xfers1_q + CW'(1);
          end
        end else begin
          rdata0_d = mem_rdata;
          if (xfers0_q != '1) begin
            xfers0_d = xfers0_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      xfers0_q    <= '0;
      xfers1_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      xfers0_q    <= xfers0_d;
      xfers1_q    <= xfers1_d;
    end
  end

  // Output decode. During RESP the owner sees memory data directly so rdata
  // is valid alongside ack; afterwards the captured copy is held.
  always_comb begin
    in_resp  = (state_q == ST_RESP);
    m0_ack   = in_resp && !grant_q;
    m1_ack   = in_resp &&  grant_q;
    m0_rdata = m0_ack ? mem_rdata : rdata0_q;
    m1_rdata = m1_ack ? mem_rdata : rdata1_q;
    if ((state_q == ST_ACCESS) || (state_q == ST_RESP)) begin
      owner = grant_q ? 2'b10 : 2'b01;
    end else begin
      owner = 2'b00;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign m0_xfers  = xfers0_q;
  assign m1_xfers  = xfers1_q;

  a_ack_exclusive: assert property (@(posedge clock) disable iff (reset)
    !(m0_ack && m1_ack));
  a_owner_onehot0: assert property (@(posedge clock) disable iff (reset)
    $onehot0(owner));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_dmem_arbiter;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 3;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clock;
  logic          reset;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    owner;
  logic [CW-1:0] m0_xfers, m1_xfers;

  dmem_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .owner(owner), .m0_xfers(m0_xfers), .m1_xfers(m1_xfers)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h0101_0101) ^ 32'hA500_0000;
  endfunction

  // Memory environment: synchronous read (read-before-write), 64 words.
  // It uses the memory-side outputs captured at the preceding negedge.
  logic          cap_we;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic [31:0]   mem [0:63];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_rdata <= '0;
    end else begin
      mem_rdata <= mem[cap_addr[7:2]];
      if (cap_we) mem[cap_addr[7:2]] <= cap_wdata;
    end
  end

  // Transaction-level model: t counts edges since reset; a transfer granted
  // at edge s occupies intervals s (memory access) and s+1 (ack), and the
  // next grant can happen at edge s+3.
  int          t, s, w, last_srv, cnt0, cnt1;
  logic        twe;
  logic [31:0] taddr, twdata, rdval, exp_rd0, exp_rd1, exp_addr, exp_wdata;
  logic [31:0] shadow [0:63];

  task automatic model_reset();
    t = 0; s = -10; w = 0; last_srv = 1; cnt0 = 0; cnt1 = 0;
    twe = 1'b0; taddr = '0; twdata = '0; rdval = '0;
    exp_rd0 = '0; exp_rd1 = '0; exp_addr = '0; exp_wdata = '0;
    for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
    cap_we = 1'b0;
  endtask

  task automatic model_step();
    t = t + 1;
    if (t == s + 2) begin
      if (w == 0) begin
        if (cnt0 < CMAX) cnt0++;
        exp_rd0 = rdval;
      end else begin
        if (cnt1 < CMAX) cnt1++;
        exp_rd1 = rdval;
      end
      last_srv = w;
      if (twe) shadow[taddr[7:2]] = twdata;
    end
    if (t >= s + 3 && (m0_req || m1_req)) begin
      if (m0_req && m1_req) w = (last_srv == 1) ? 0 : 1;
      else                  w = m0_req ? 0 : 1;
      s      = t;
      twe    = (w == 1) ? m1_we    : m0_we;
      taddr  = (w == 1) ? m1_addr  : m0_addr;
      twdata = (w == 1) ? m1_wdata : m0_wdata;
      rdval  = shadow[taddr[7:2]];
      exp_addr  = taddr;
      exp_wdata = twdata;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 60)
        $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic busy, resp;
    busy = (t == s) || (t == s + 1);
    resp = (t == s + 1);
    chk("owner",     owner,     busy ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00);
    chk("mem_we",    mem_we,    (t == s) ? twe : 1'b0);
    chk("mem_addr",  mem_addr,  exp_addr);
    chk("mem_wdata", mem_wdata, exp_wdata);
    chk("m0_ack",    m0_ack,    resp && w == 0);
    chk("m1_ack",    m1_ack,    resp && w == 1);
    chk("m0_rdata",  m0_rdata,  (resp && w == 0) ? rdval : exp_rd0);
    chk("m1_rdata",  m1_rdata,  (resp && w == 1) ? rdval : exp_rd1);
    chk("m0_xfers",  m0_xfers,  cnt0);
    chk("m1_xfers",  m1_xfers,  cnt1);
  endtask

  // One cycle: advance the model for the edge just taken, compare, then
  // capture memory-side outputs for the memory environment.
  task automatic tick();
    @(negedge clock);
    if (reset) model_reset();
    else       model_step();
    compare_model();
    cap_we    = mem_we;
    cap_addr  = mem_addr;
    cap_wdata = mem_wdata;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    model_reset();
    idle_inputs();
    tick(); tick();
    #2 reset = 1'b0;
  endtask

  task automatic rand_master(input bit sticky, inout logic req, inout logic we,
                             inout logic [31:0] addr, inout logic [31:0] wdata);
    if ($urandom_range(0, 3) == 0) begin
      req   = sticky ? 1'b1 : ($urandom_range(0, 2) != 0);
      we    = $urandom_range(0, 1) == 1;
      addr  = $urandom;
      wdata = $urandom;
    end
  endtask

  initial begin
    cap_we = 1'b0; cap_addr = '0; cap_wdata = '0;
    reset  = 1'b1;
    idle_inputs();
    model_reset();

    // Reset state
    reset_dut();
    chk("rst_owner",  owner,    2'b00);
    chk("rst_mem_we", mem_we,   1'b0);
    chk("rst_xfers",  m0_xfers, 0);

    // Single read by m0 at 0x10
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    tick();
    chk("rd_mem_addr", mem_addr, 32'h10);
    chk("rd_mem_we",   mem_we,   1'b0);
    chk("rd_owner",    owner,    2'b01);
    tick();
    chk("rd_ack",      m0_ack,   1'b1);
    chk("rd_rdata",    m0_rdata, 32'hDEADBEEF);
    #2 m0_req = 0;
    tick();
    chk("rd_ack_gone", m0_ack,   1'b0);
    chk("rd_xfers",    m0_xfers, 1);
    chk("rd_held",     m0_rdata, 32'hDEADBEEF);

    // Single write by m1 at 0x80
    #2 m1_req = 1; m1_we = 1; m1_addr = 32'h80; m1_wdata = 32'h55AA55AA;
    tick();
    chk("wr_mem_we",    mem_we,    1'b1);
    chk("wr_mem_addr",  mem_addr,  32'h80);
    chk("wr_mem_wdata", mem_wdata, 32'h55AA55AA);
    chk("wr_owner",     owner,     2'b10);
    tick();
    chk("wr_mem_we_off", mem_we, 1'b0);
    chk("wr_m1_ack",     m1_ack, 1'b1);
    chk("wr_m0_ack",     m0_ack, 1'b0);
    #2 m1_req = 0;
    tick();
    chk("wr_m1_ack_gone", m1_ack,   1'b0);
    chk("wr_xfers",       m1_xfers, 1);

    // Input change after grant: address moves 0x10 -> 0x20 during ACCESS
    #2 m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    tick();
    #2 m0_addr = 32'h20;
    tick();
    chk("chg_mem_addr", mem_addr, 32'h10);
    chk("chg_rdata",    m0_rdata, 32'hDEADBEEF);
    #2 m0_req = 0;
    tick();

    // Simultaneous requests from reset: m0 first, then strict alternation
    reset_dut();
    m0_req = 1; m0_addr = 32'h0; m1_req = 1; m1_addr = 32'h4;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk("alt_m0_ack", m0_ack, (k % 3 == 2) && (((k - 2) / 3) % 2 == 0));
      chk("alt_m1_ack", m1_ack, (k % 3 == 2) && (((k - 2) / 3) % 2 == 1));
      if (k == 30) begin
        chk("alt_m0_xfers", m0_xfers, 5);
        chk("alt_m1_xfers", m1_xfers, 5);
        #2 m0_req = 0; m1_req = 0;
      end
    end
    tick();

    // Reset during ACCESS of a write
    reset_dut();
    m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'h12345678;
    @(posedge clock);
    #2 chk("mid_we_before", mem_we, 1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("mid_we_async", mem_we,   1'b0);
    chk("mid_owner",    owner,    2'b00);
    chk("mid_ack",      m0_ack,   1'b0);
    chk("mid_xfers",    m0_xfers, 0);
    m0_req = 0;
    tick(); tick();
    #2 reset = 1'b0;
    tick(); tick();
    chk("mid_owner_after", owner,    2'b00);
    chk("mid_xfers_after", m0_xfers, 0);
    chk("mid_ack_after",   m0_ack,   1'b0);

    // Saturation: nine back-to-back m0 transfers with a 3-bit counter
    reset_dut();
    m0_req = 1; m0_we = 0; m0_addr = 32'h8;
    for (int k = 1; k <= 27; k++) begin
      tick();
      if (k == 21) chk("sat_x7", m0_xfers, 7);
      if (k == 27) begin
        chk("sat_hold", m0_xfers, 7);
        #2 m0_req = 0;
      end
    end
    tick();

    // Randomized traffic; segment 0 keeps both masters requesting
    for (int seg = 0; seg < 4; seg++) begin
      reset_dut();
      for (int c = 0; c < 400; c++) begin
        tick();
        #2;
        rand_master(seg == 0, m0_req, m0_we, m0_addr, m0_wdata);
        rand_master(seg == 0, m1_req, m1_we, m1_addr, m1_wdata);
        if ($urandom_range(0, 299) == 0) begin
          reset = 1'b1;
          model_reset();
          tick();
          #2 reset = 1'b0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
